// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter in front of the SDRAM controller: one operation in flight,
// bounded client-0 priority, and a watchdog that aborts unacknowledged operations.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_ack,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_ack,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wack,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rack,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic              busy
);
    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner;      // 1 = client 1 holds the current operation
    logic          op_we;
    logic [CW-1:0] consec0;
    logic [TW-1:0] tcnt;
    logic          grant0, grant1, done, abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_nxt = WAIT;
            WAIT:    if (done || abort)    state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded control; only the acknowledge matching the operation type counts,
    // and a matching acknowledge on the final timeout cycle still completes normally.
    always_comb begin
        grant1 = (state == IDLE) && c1_req && (!c0_req || consec0 == CW'(MAX_CONSEC));
        grant0 = (state == IDLE) && c0_req && !grant1;
        done   = (state == WAIT) && (op_we ? mem_wack : mem_rack);
        abort  = (state == WAIT) && !done && (tcnt == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= 1'b0;
            op_we       <= 1'b0;
            consec0     <= '0;
            tcnt        <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            c0_rdata    <= '0;
            c1_rdata    <= '0;
            c0_ack      <= 1'b0;
            c1_ack      <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            c0_ack <= (done || abort) && !owner;
            c1_ack <= (done || abort) && owner;
            busy   <= (state_nxt != IDLE);

            if (state == IDLE) begin
                tcnt <= '0;
                if (grant1) begin
                    owner   <= 1'b1;
                    op_we   <= c1_we;
                    consec0 <= '0;
                    if (c1_we) begin
                        mem_wr    <= 1'b1;
                        mem_waddr <= c1_addr;
                        mem_wdata <= c1_wdata;
                    end else begin
                        mem_rd    <= 1'b1;
                        mem_raddr <= c1_addr;
                    end
                end else if (grant0) begin
                    owner     <= 1'b0;
                    op_we     <= 1'b0;
                    mem_rd    <= 1'b1;
                    mem_raddr <= c0_addr;
                    if (!c1_req)
                        consec0 <= '0;
                    else if (consec0 != CW'(MAX_CONSEC))
                        consec0 <= consec0 + CW'(1);
                end else if (!c1_req) begin
                    consec0 <= '0;
                end
            end

            if (state == WAIT) begin
                tcnt <= tcnt + TW'(1);
                if (done || abort) begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
                if (done && !op_we) begin
                    if (owner) c1_rdata <= mem_rdata;
                    else       c0_rdata <= mem_rdata;
                end else if (abort) begin
                    if (owner) c1_rdata <= '0;
                    else       c0_rdata <= '0;
                end
            end

            if (abort)        timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (MAX_CONSEC=4, TIMEOUT=8); inputs change
// on the falling edge, outputs are sampled on the falling edge.
module tb_sdram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c0_req = 1'b0, c1_req = 1'b0, c1_we = 1'b0;
    logic [31:0] c0_addr = '0, c1_addr = '0;
    logic [15:0] c1_wdata = '0, mem_rdata = '0;
    logic        mem_wack = 1'b0, mem_rack = 1'b0, err_clr = 1'b0;
    logic [15:0] c0_rdata, c1_rdata, mem_wdata;
    logic [31:0] mem_waddr, mem_raddr;
    logic        c0_ack, c1_ack, mem_wr, mem_rd, timeout_err, busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] mem_model [256];
    int owners[$];
    int rises[$];

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(32), .DATA_W(16), .MAX_CONSEC(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_rdata(c0_rdata), .c0_ack(c0_ack),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_ack(c1_ack),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
        .mem_rd(mem_rd), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rack(mem_rack),
        .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete operation; the controller acknowledges in the dly-th WAIT cycle.
    task automatic op(input bit cl, input bit we, input logic [31:0] a, input logic [15:0] wd,
                      input int dly, input logic [15:0] rd, input logic [15:0] exp_rd,
                      input string tag);
        if (cl) begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = wd; end
        else    begin c0_req = 1; c0_addr = a; end
        @(negedge clk);
        chk({tag, "_strobe"}, we ? mem_wr : mem_rd, 1);
        chk({tag, "_addr"}, we ? mem_waddr : mem_raddr, a);
        if (we) chk({tag, "_wdata"}, mem_wdata, wd);
        for (int i = 1; i < dly; i++) @(negedge clk);
        if (we) begin mem_wack = 1; mem_model[a[7:0]] = mem_wdata; end
        else    begin mem_rack = 1; mem_rdata = rd; end
        @(negedge clk);
        mem_wack = 0; mem_rack = 0; c0_req = 0; c1_req = 0;
        chk({tag, "_ack"}, cl ? c1_ack : c0_ack, 1);
        chk({tag, "_other_ack"}, cl ? c0_ack : c1_ack, 0);
        chk({tag, "_strobe_low"}, mem_rd | mem_wr, 0);
        chk({tag, "_rdata"}, cl ? c1_rdata : c0_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_ack_1cyc"}, c0_ack | c1_ack, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    // Free-running controller acking every read/write on its second WAIT cycle.
    task automatic stream(input int ncyc, input int max_acks);
        int  wcnt = 0;
        logic prev = 0;
        for (int i = 1; i <= ncyc && owners.size() < max_acks; i++) begin
            @(negedge clk);
            mem_rack = 0; mem_wack = 0;
            if (c0_ack) owners.push_back(0);
            if (c1_ack) owners.push_back(1);
            if (mem_rd && !prev) rises.push_back(i);
            prev = mem_rd;
            if (mem_rd || mem_wr) wcnt++; else wcnt = 0;
            if (wcnt == 2) begin
                if (mem_rd) begin mem_rack = 1; mem_rdata = 16'h1111; end
                else mem_wack = 1;
            end
        end
        mem_rack = 0; mem_wack = 0;
    endtask

    task automatic tmo(input bit clr, input string tag);
        int hi = 0;
        bit got = 0;
        err_clr = clr; c0_req = 1; c0_addr = 32'h300;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_rd) hi++;
            if (c0_ack) got = 1;
        end
        c0_req = 0; err_clr = 0;
        chk({tag, "_ack_seen"}, got, 1);
        chk({tag, "_rd_cycles"}, hi, 8);
        chk({tag, "_rdata_zero"}, c0_rdata, 0);
        chk({tag, "_err"}, timeout_err, 1);
        @(negedge clk);
    endtask

    initial begin
        int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        #12;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {c0_ack, c1_ack}, 0);
        chk("rst_err", timeout_err, 0);
        @(negedge clk); reset = 0;
        @(negedge clk);

        op(0, 0, 32'h0000_1000, 16'h0, 2, 16'hBEEF, 16'hBEEF, "rd0");
        op(1, 1, 32'h20, 16'hA5A5, 1, 16'h0, 16'h0000, "wr1");
        op(1, 0, 32'h20, 16'h0, 1, mem_model[8'h20], 16'hA5A5, "rb1");
        chk("c0_rdata_hold", c0_rdata, 16'hBEEF);

        rises.delete(); owners.delete();
        c0_req = 1; c0_addr = 32'h40;
        stream(12, 100);
        c0_req = 0;
        chk("solo_grants", rises.size(), 3);
        for (int i = 0; i < 3 && i < rises.size(); i++) chk("solo_period", rises[i], 1 + 4 * i);
        chk("solo_acks", owners.size(), 3);

        owners.delete();
        c0_req = 1; c1_req = 1; c1_we = 0; c1_addr = 32'h80;
        stream(80, 10);
        c0_req = 0; c1_req = 0;
        chk("cont_count", owners.size(), 10);
        for (int i = 0; i < 10 && i < owners.size(); i++) chk("cont_order", owners[i], exp_order[i]);
        @(negedge clk);

        c0_req = 1; c0_addr = 32'h500;
        @(negedge clk);
        mem_wack = 1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_wack = 0;
        chk("mism_still_rd", mem_rd, 1);
        chk("mism_no_ack", c0_ack, 0);
        mem_rack = 1; mem_rdata = 16'h7E57;
        @(negedge clk);
        mem_rack = 0; c0_req = 0;
        chk("mism_ack", c0_ack, 1);
        chk("mism_rdata", c0_rdata, 16'h7E57);
        @(negedge clk);

        tmo(0, "tmo1");
        mem_rack = 1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        mem_rack = 0;
        chk("late_rack_ack", c0_ack, 0);
        chk("late_rack_rdata", c0_rdata, 0);
        chk("late_rack_busy", busy, 0);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        chk("err_clr", timeout_err, 0);
        tmo(1, "tmo2");
        chk("err_set_wins_hold", timeout_err, 1);

        c1_req = 1; c1_we = 1; c1_addr = 32'h44; c1_wdata = 16'h1357;
        @(negedge clk);
        chk("midwait_wr", mem_wr, 1);
        reset = 1;
        #1;
        chk("arst_wr", mem_wr, 0);
        chk("arst_waddr", mem_waddr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", timeout_err, 0);
        chk("arst_c1_rdata", c1_rdata, 0);
        @(negedge clk); reset = 0;
        @(negedge clk);
        chk("regrant_wr", mem_wr, 1);
        chk("regrant_addr", mem_waddr, 32'h44);
        mem_wack = 1;
        @(negedge clk);
        mem_wack = 0; c1_req = 0;
        chk("regrant_ack", c1_ack, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
